beat_tone_gen: RTL and testbench

Consumer of the beat index produced by the player control block. It follows `ibeat`, fetches the score word for each new beat from an external synchronous score ROM, and turns it into a square-wave 16-bit audio sample stream with volume, mute, and pause handling. Between two identical untied notes it inserts a short silence so repeated notes are audible as separate hits. It sits between the player control block and the audio DAC serializer.

---
 rtl/beat_tone_gen.sv | 149 ++++++++++++++
 tb/tb_beat_tone_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/beat_tone_gen.sv
// Follows the player's beat index, fetches the score word for each new beat from a
// synchronous ROM and renders it as a square-wave 16-bit sample stream.
module beat_tone_gen #(
  parameter int BEAT_W     = 12,
  parameter int PERIOD_W   = 21,
  parameter int GAP_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BEAT_W-1:0]   ibeat,
  input  logic                play_pause,
  input  logic                mute,
  input  logic [2:0]          volume,
  output logic [BEAT_W-1:0]   rom_addr,
  input  logic [PERIOD_W:0]   rom_data,
  output logic [15:0]         audio,
  output logic                note_busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   rom_addr_q, rom_addr_d;
  logic [BEAT_W-1:0]   ibeat_q, ibeat_d;
  logic                first_q, first_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] hcnt_q, hcnt_d;
  logic                phase_q, phase_d;
  logic                gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [15:0]         audio_q, audio_d;
  logic                note_busy_q, note_busy_d;

  logic                change;
  logic [PERIOD_W-1:0] period_next;
  logic                tie_next;
  logic [2:0]          vol_c;
  logic [15:0]         amp;

  assign change      = (ibeat != ibeat_q);
  assign period_next = rom_data[PERIOD_W-1:0];
  assign tie_next    = rom_data[PERIOD_W];

  always_comb begin
    vol_c = (volume > 3'd5) ? 3'd5 : volume;
    amp   = '0;
    if (vol_c != 3'd0) amp = 16'h0400 << (vol_c - 3'd1);
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    ibeat_d     = ibeat;
    first_d     = first_q;
    period_d    = period_q;
    hcnt_d      = hcnt_q;
    phase_d     = phase_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;

    // Tone and gap timers only advance while playing; pause freezes them.
    if (play_pause) begin
      if (gap_q) begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d     = 1'b0;
          gap_cnt_d = '0;
          hcnt_d    = '0;
          phase_d   = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end else if (period_q != '0) begin
        if (hcnt_q == period_q - PERIOD_W'(1)) begin
          hcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          hcnt_d  = hcnt_q + PERIOD_W'(1);
        end
      end
    end

    // first_q can only be set in IDLE, so one restart test covers every state.
    if (change || first_q) begin
      state_d    = S_FETCH;
      rom_addr_d = ibeat;
      first_d    = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_WAIT:  state_d = S_LOAD;
        S_LOAD: begin
          state_d  = S_PLAY;
          period_d = period_next;
          if (period_next == period_q && period_q != '0 && tie_next) begin
            // tied repeat keeps running phase and counter
          end else begin
            hcnt_d    = '0;
            phase_d   = 1'b1;
            gap_d     = (period_next == period_q) && (period_q != '0);
            gap_cnt_d = '0;
          end
        end
        S_IDLE, S_PLAY: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end

    note_busy_d = (state_d != S_PLAY);

    audio_d = '0;
    if (state_q == S_PLAY && play_pause && !mute && !gap_q && period_q != '0)
      audio_d = phase_q ? amp : (16'h0000 - amp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      ibeat_q     <= '0;
      first_q     <= 1'b1;
      period_q    <= '0;
      hcnt_q      <= '0;
      phase_q     <= 1'b0;
      gap_q       <= 1'b0;
      gap_cnt_q   <= '0;
      audio_q     <= '0;
      note_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      ibeat_q     <= ibeat_d;
      first_q     <= first_d;
      period_q    <= period_d;
      hcnt_q      <= hcnt_d;
      phase_q     <= phase_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      audio_q     <= audio_d;
      note_busy_q <= note_busy_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign audio     = audio_q;
  assign note_busy = note_busy_q;

endmodule

// File: tb/tb_beat_tone_gen.sv
// Scoreboard bench for beat_tone_gen: an event-level note model predicts every
// registered output; a negedge monitor pops and compares.
module tb_beat_tone_gen;
  localparam int BW = 12;
  localparam int PW = 21;
  localparam int G  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] ibeat;
  logic          play_pause, mute;
  logic [2:0]    volume;
  logic [BW-1:0] rom_addr;
  logic [PW:0]   rom_data;
  logic [15:0]   audio;
  logic          note_busy;

  logic [PW:0] rom [0:4095];

  beat_tone_gen #(.BEAT_W(BW), .PERIOD_W(PW), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .ibeat(ibeat), .play_pause(play_pause), .mute(mute),
    .volume(volume), .rom_addr(rom_addr), .rom_data(rom_data), .audio(audio),
    .note_busy(note_busy));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [15:0]   audio;
    logic [BW-1:0] addr;
    logic          busy;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // Note-level model: a fetch is an age counter, a tone is elapsed play time.
  int m_stage, m_addr, m_ib_prev, m_period, m_play_t, m_gap_left;
  bit m_first;

  task automatic model_reset();
    m_stage = 0; m_addr = 0; m_ib_prev = 0; m_period = 0;
    m_play_t = 0; m_gap_left = 0; m_first = 1;
    exp_q.delete();
  endtask

  function automatic logic [15:0] exp_audio(input int vol, input bit pp, input bit mt);
    int v, a;
    bit high;
    v = (vol > 5) ? 5 : vol;
    a = (v == 0) ? 0 : (1024 << (v - 1));
    if (m_stage != 0 || !pp || mt || m_gap_left > 0 || m_period == 0) return 16'h0;
    high = ((m_play_t / m_period) % 2) == 0;
    return high ? 16'(a) : 16'(-a);
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      exp_t e;
      int np;
      bit nt;
      e.audio = exp_audio(int'(volume), play_pause, mute);
      if (play_pause) begin
        if (m_gap_left > 0) m_gap_left--;
        else if (m_period != 0) m_play_t++;
      end
      if (int'(ibeat) != m_ib_prev || m_first) begin
        m_stage = 1; m_addr = int'(ibeat); m_first = 0;
      end else if (m_stage == 3) begin
        np = int'(rom[m_addr][PW-1:0]);
        nt = rom[m_addr][PW];
        if (!(np == m_period && m_period != 0 && nt)) begin
          m_play_t   = 0;
          m_gap_left = (np == m_period && m_period != 0) ? G : 0;
        end
        m_period = np;
        m_stage = 0;
      end else if (m_stage != 0) begin
        m_stage++;
      end
      m_ib_prev = int'(ibeat);
      e.addr = BW'(m_addr);
      e.busy = (m_stage != 0);
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk += 3;
      if (audio !== e.audio) begin
        n_fail++; $display("FAIL audio t=%0t got %h want %h", $time, audio, e.audio);
      end
      if (rom_addr !== e.addr) begin
        n_fail++; $display("FAIL rom_addr t=%0t got %0d want %0d", $time, rom_addr, e.addr);
      end
      if (note_busy !== e.busy) begin
        n_fail++; $display("FAIL note_busy t=%0t got %b want %b", $time, note_busy, e.busy);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_chk += 3;
    if (audio !== 16'h0) begin n_fail++; $display("FAIL %s_audio got %h want 0000", tag, audio); end
    if (rom_addr !== '0) begin n_fail++; $display("FAIL %s_rom_addr got %0d want 0", tag, rom_addr); end
    if (note_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy got %b want 0", tag, note_busy); end
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs(tag);
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_cond(input int which, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if ((which == 0 && m_stage == 2) || (which == 1 && m_gap_left > 0 && m_stage == 0)) begin
        ok = 1; break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_chk++; n_fail++; $display("FAIL %s_timeout got none want event", tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; ibeat = '0; play_pause = 1'b1; mute = 1'b0; volume = 3'd3;
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    for (int i = 0; i < 16; i++) begin
      int pr;
      pr = int'($urandom_range(0, 4));
      rom[i] = {1'($urandom_range(0, 1)), PW'((pr == 4) ? 3 : pr + 1)};
    end
    rom[0] = {1'b0, PW'(0)};
    rom[1] = {1'b0, PW'(2)}; rom[2] = {1'b0, PW'(3)}; rom[3] = {1'b0, PW'(5)};
    rom[5] = {1'b0, PW'(4)}; rom[6] = {1'b0, PW'(4)}; rom[7] = {1'b1, PW'(4)};
    rom[8] = {1'b0, PW'(0)}; rom[9] = {1'b0, PW'(3)}; rom[10] = {1'b0, PW'(2)};
    rom[11] = {1'b0, PW'(6)}; rom[12] = {1'b0, PW'(3)}; rom[13] = {1'b0, PW'(3)};
    rom[4095] = {1'b0, PW'(2)};
    model_reset();
    ibeat = 12'd5;
    cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(30);                                  // basic note
    ibeat = 12'd6; cyc(30);                   // repeat untied -> gap
    ibeat = 12'd7; cyc(20);                   // tied repeat -> continuous
    ibeat = 12'd1; cyc(1); ibeat = 12'd2; cyc(1); ibeat = 12'd3; cyc(20);
    ibeat = 12'd8; cyc(10);                   // rest
    ibeat = 12'd9; cyc(8); mute = 1'b1; cyc(5); mute = 1'b0; cyc(8);
    volume = 3'd7; cyc(8); volume = 3'd5; cyc(8); volume = 3'd0; cyc(6); volume = 3'd3;
    wait (dut.hcnt_q == 21'd2); @(negedge clk);
    play_pause = 1'b0; cyc(4); ibeat = 12'd10; cyc(6); play_pause = 1'b1; cyc(12);
    ibeat = 12'd11; wait_cond(0, "wait_state"); async_reset("rst_wait"); cyc(20);
    ibeat = 12'd12; cyc(12); ibeat = 12'd13; wait_cond(1, "gap_state"); cyc(2);
    async_reset("rst_gap"); cyc(20);
    ibeat = 12'd4095; cyc(10); ibeat = 12'd0; cyc(10);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) ibeat = BW'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) play_pause = ~play_pause;
      if ($urandom_range(0, 19) == 0) mute = ~mute;
      if ($urandom_range(0, 15) == 0) volume = 3'($urandom_range(0, 7));
      cyc(1);
    end
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
